// File: rtl/iob_regfile_wr_arbiter.sv
// iob_regfile_wr_arbiter: round-robin arbiter for the single write port of a
// two-port register file, with a built-in clear sequencer that zeroes every
// entry. Optional owner lock enabled by defining IOB_REGFILE_ARB_LOCK_EN.
module iob_regfile_wr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 21
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    cke_i,
  input  logic                    clear_i,
  output logic                    busy_o,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        lock_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    w_cke_o,
  output logic [ADDR_W-1:0]       w_addr_o,
  output logic [DATA_W-1:0]       w_data_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(N_REQ - 1);

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                w_cke_q, w_cke_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [N_REQ-1:0]    ack_c;
  logic [N_REQ-1:0]    elig;
  logic                gnt_found;
  int unsigned         gnt_idx;
  int unsigned         cand;

`ifdef IOB_REGFILE_ARB_LOCK_EN
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                locked_q, locked_d;
  logic                lock_hold;

  // Lock releases in the same cycle lock_i[owner] drops
  assign lock_hold = locked_q & lock_i[owner_q];

  // While the lock holds, only the owner may compete
  always_comb begin
    elig = req_i;
    if (lock_hold) begin
      elig          = '0;
      elig[owner_q] = req_i[owner_q];
    end
  end

  // Lock ownership: taken by a grant with lock_i set, dropped on clear
  always_comb begin
    owner_d  = owner_q;
    locked_d = locked_q;
    if (cke_i) begin
      if (state_q == ST_CLEAR || clear_i) begin
        locked_d = 1'b0;
      end else begin
        locked_d = lock_hold;
        if (gnt_found && lock_i[gnt_idx]) begin
          owner_d  = PTR_W'(gnt_idx);
          locked_d = 1'b1;
        end
      end
    end
  end

  // Lock registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      owner_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign elig        = req_i;
`endif

  // Round-robin search starting one past the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 0;
    cand      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(last_q) + 1 + i) % N_REQ;
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Next-state, grant and write-port load decisions
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    w_cke_d  = w_cke_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    ack_c    = '0;
    if (cke_i) begin
      unique case (state_q)
        ST_RUN: begin
          if (clear_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            w_cke_d = 1'b0;
          end else if (gnt_found) begin
            ack_c[gnt_idx] = 1'b1;
            w_cke_d        = 1'b1;
            w_addr_d       = addr_i[gnt_idx*ADDR_W +: ADDR_W];
            w_data_d       = data_i[gnt_idx*DATA_W +: DATA_W];
            last_d         = PTR_W'(gnt_idx);
          end else begin
            w_cke_d = 1'b0;
          end
        end
        ST_CLEAR: begin
          w_cke_d  = 1'b1;
          w_addr_d = cnt_q;
          w_data_d = '0;
          if (cnt_q == '1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State, pointer, counter and registered write-port outputs
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_RUN;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      w_cke_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      w_cke_q  <= w_cke_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign ack_o    = ack_c;
  assign busy_o   = (state_q == ST_CLEAR);
  assign w_cke_o  = w_cke_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;

endmodule

// File: tb/tb_iob_regfile_wr_arbiter.sv
// Directed testbench for iob_regfile_wr_arbiter (N_REQ=4, ADDR_W=3, DATA_W=21).
// Lock expectations follow IOB_REGFILE_ARB_LOCK_EN when it is defined.
module tb_iob_regfile_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 21;

  logic          clk = 1'b0;
  logic          arst, cke, clear, busy;
  logic [N-1:0]  req, lock, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic          w_cke;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] A [N];
  logic [DW-1:0] D [N];

  iob_regfile_wr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .clear_i(clear), .busy_o(busy),
    .req_i(req), .lock_i(lock), .addr_i(addr), .data_i(data), .ack_o(ack),
    .w_cke_o(w_cke), .w_addr_o(w_addr), .w_data_o(w_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus;
    for (int k = 0; k < N; k++) begin
      addr[k*AW +: AW] = A[k];
      data[k*DW +: DW] = D[k];
    end
  endtask

  task automatic test_reset;
    arst = 1'b1; cke = 1'b1; clear = 1'b0; req = '0; lock = '0;
    A[0] = 3'd2; A[1] = 3'd3; A[2] = 3'd4; A[3] = 3'd6;
    D[0] = 21'h01111; D[1] = 21'h02222; D[2] = 21'h13333; D[3] = 21'h1FFFFF;
    drive_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (w_cke !== 1'b0) begin errors++; $display("FAIL rst_w_cke: got %b exp 0", w_cke); end
    checks++; if (w_addr !== 3'd0) begin errors++; $display("FAIL rst_w_addr: got %0d exp 0", w_addr); end
    checks++; if (w_data !== 21'd0) begin errors++; $display("FAIL rst_w_data: got %h exp 0", w_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b exp 0000", ack); end
    tick();
    arst = 1'b0;
  endtask

  task automatic test_priority;
    logic [N-1:0] exp_ack;
    int p;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_ack = 4'(1 << (i % 4));
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL prio_ack[%0d]: got %b exp %b", i, ack, exp_ack); end
      if (i > 0) begin
        p = (i - 1) % 4;
        checks++; if (w_cke !== 1'b1 || w_addr !== A[p] || w_data !== D[p]) begin
          errors++; $display("FAIL prio_write[%0d]: got cke=%b addr=%0d data=%h exp cke=1 addr=%0d data=%h", i, w_cke, w_addr, w_data, A[p], D[p]);
        end
      end
      tick();
    end
    req = '0;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL prio_idle_ack: got %b exp 0000", ack); end
    checks++; if (w_cke !== 1'b1 || w_addr !== A[3] || w_data !== D[3]) begin
      errors++; $display("FAIL prio_last_write: got cke=%b addr=%0d data=%h exp cke=1 addr=%0d data=%h", w_cke, w_addr, w_data, A[3], D[3]);
    end
    tick();
    @(negedge clk);
    checks++; if (w_cke !== 1'b0 || w_addr !== A[3] || w_data !== D[3]) begin
      errors++; $display("FAIL prio_hold: got cke=%b addr=%0d data=%h exp cke=0 addr=%0d data=%h", w_cke, w_addr, w_data, A[3], D[3]);
    end
    tick();
  endtask

  task automatic test_single_write;
    A[2] = 3'd5; D[2] = 21'h1ABCD;
    drive_bus();
    req = 4'b0100;
    @(negedge clk);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b exp 0100", ack); end
    tick();
    req = '0;
    @(negedge clk);
    checks++; if (w_cke !== 1'b1 || w_addr !== 3'd5 || w_data !== 21'h1ABCD) begin
      errors++; $display("FAIL single_write: got cke=%b addr=%0d data=%h exp cke=1 addr=5 data=1abcd", w_cke, w_addr, w_data);
    end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_idle_ack: got %b exp 0000", ack); end
    tick();
    @(negedge clk);
    checks++; if (w_cke !== 1'b0) begin errors++; $display("FAIL single_cke_drop: got %b exp 0", w_cke); end
    tick();
  endtask

  task automatic test_clear;
    req = 4'b0011; clear = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL clr_pulse_ack: got %b exp 0000", ack); end
    tick();
    clear = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || ack !== 4'b0000) begin
        errors++; $display("FAIL clr_busy[%0d]: got busy=%b ack=%b exp busy=1 ack=0000", j, busy, ack);
      end
      if (j == 0) begin
        checks++; if (w_cke !== 1'b0) begin errors++; $display("FAIL clr_first_cke: got %b exp 0", w_cke); end
      end else begin
        checks++; if (w_cke !== 1'b1 || w_addr !== 3'(j - 1) || w_data !== 21'd0) begin
          errors++; $display("FAIL clr_write[%0d]: got cke=%b addr=%0d data=%h exp cke=1 addr=%0d data=0", j, w_cke, w_addr, w_data, j - 1);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_end_busy: got %b exp 0", busy); end
    checks++; if (w_cke !== 1'b1 || w_addr !== 3'd7 || w_data !== 21'd0) begin
      errors++; $display("FAIL clr_last_write: got cke=%b addr=%0d data=%h exp cke=1 addr=7 data=0", w_cke, w_addr, w_data);
    end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL clr_after_ack: got %b exp 0001", ack); end
    tick();
    req = '0;
    @(negedge clk);
    checks++; if (w_cke !== 1'b1 || w_addr !== A[0] || w_data !== D[0]) begin
      errors++; $display("FAIL clr_after_write: got cke=%b addr=%0d data=%h exp cke=1 addr=%0d data=%h", w_cke, w_addr, w_data, A[0], D[0]);
    end
    tick();
  endtask

  task automatic test_cke_stall;
    int hits [8];
    bit stall;
    for (int a = 0; a < 8; a++) hits[a] = 0;
    req = 4'b0011; clear = 1'b1;
    @(negedge clk);
    tick();
    clear = 1'b0;
    for (int c = 0; c < 12; c++) begin
      stall = (c >= 4 && c <= 6);
      cke = stall ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c <= 10) begin
        checks++; if (busy !== 1'b1 || ack !== 4'b0000) begin
          errors++; $display("FAIL stall_busy[%0d]: got busy=%b ack=%b exp busy=1 ack=0000", c, busy, ack);
        end
      end else begin
        checks++; if (busy !== 1'b0 || ack !== 4'b0010) begin
          errors++; $display("FAIL stall_resume_run: got busy=%b ack=%b exp busy=0 ack=0010", busy, ack);
        end
      end
      if (stall) begin
        checks++; if (w_cke !== 1'b1 || w_addr !== 3'd3) begin
          errors++; $display("FAIL stall_hold[%0d]: got cke=%b addr=%0d exp cke=1 addr=3", c, w_cke, w_addr);
        end
      end
      if (w_cke === 1'b1 && cke === 1'b1) begin
        hits[w_addr]++;
        checks++; if (w_data !== 21'd0) begin errors++; $display("FAIL stall_zero[%0d]: got %h exp 0", c, w_data); end
      end
      tick();
    end
    for (int a = 0; a < 8; a++) begin
      checks++; if (hits[a] != 1) begin errors++; $display("FAIL stall_once[%0d]: got %0d writes exp 1", a, hits[a]); end
    end
    cke = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 4'b0000 || w_addr !== A[1]) begin
      errors++; $display("FAIL run_stall: got ack=%b addr=%0d exp ack=0000 addr=%0d", ack, w_addr, A[1]);
    end
    tick();
    cke = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 4'b0001 || w_addr !== A[1]) begin
      errors++; $display("FAIL run_stall_resume: got ack=%b addr=%0d exp ack=0001 addr=%0d", ack, w_addr, A[1]);
    end
    tick();
    req = '0;
    @(negedge clk);
    checks++; if (w_addr !== A[0] || w_data !== D[0]) begin
      errors++; $display("FAIL run_stall_write: got addr=%0d data=%h exp addr=%0d data=%h", w_addr, w_data, A[0], D[0]);
    end
    tick();
  endtask

  task automatic test_lock;
    logic [N-1:0] exp_lock [6];
`ifdef IOB_REGFILE_ARB_LOCK_EN
    exp_lock[0] = 4'b0010; exp_lock[1] = 4'b0010; exp_lock[2] = 4'b0010;
    exp_lock[3] = 4'b0100; exp_lock[4] = 4'b1000; exp_lock[5] = 4'b0001;
`else
    exp_lock[0] = 4'b0010; exp_lock[1] = 4'b0100; exp_lock[2] = 4'b1000;
    exp_lock[3] = 4'b0001; exp_lock[4] = 4'b0010; exp_lock[5] = 4'b0100;
`endif
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      lock = (i < 3) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      checks++; if (ack !== exp_lock[i]) begin errors++; $display("FAIL lock_ack[%0d]: got %b exp %b", i, ack, exp_lock[i]); end
      tick();
    end
    req = '0; lock = '0;
    tick();
  endtask

  task automatic test_async_reset;
    clear = 1'b1;
    @(negedge clk);
    tick();
    clear = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || w_addr !== 3'd2) begin
      errors++; $display("FAIL arst_pre: got busy=%b addr=%0d exp busy=1 addr=2", busy, w_addr);
    end
    #2 arst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || w_cke !== 1'b0 || w_addr !== 3'd0 || w_data !== 21'd0) begin
      errors++; $display("FAIL arst_mid: got busy=%b cke=%b addr=%0d data=%h exp all 0", busy, w_cke, w_addr, w_data);
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL arst_rearb: got %b exp 0001", ack); end
    tick();
    req = '0;
    @(negedge clk);
    checks++; if (w_cke !== 1'b1 || w_addr !== A[0] || w_data !== D[0]) begin
      errors++; $display("FAIL arst_write: got cke=%b addr=%0d data=%h exp cke=1 addr=%0d data=%h", w_cke, w_addr, w_data, A[0], D[0]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_single_write();
    test_clear();
    test_cke_stall();
    test_lock();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
